// File: rtl/lc3b_fetch_unit.sv
// lc3b_fetch_unit: LC-3b IF stage owning the PC, icache handshake and IF/ID register
module lc3b_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] BUBBLE   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic [15:0] icache_rdata,
  input  logic        icache_resp,
  output logic [15:0] if_inst,
  output logic        if_valid,
  input  logic [15:0] ctl_inst,
  input  logic        ctl_issue,
  input  logic        pc_run,
  input  logic [1:0]  pcmux_sel,
  input  logic [15:0] adder_target,
  input  logic [15:0] reg_target,
  input  logic [15:0] trap_vector,
  input  logic        pipe_stall,
  output logic [15:0] id_inst,
  output logic [15:0] id_pc,
  output logic        id_valid
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state;
  logic [15:0] pc, inst_reg, pc_inc, next_pc;
  logic        issued;
  assign pc_inc         = pc + 16'd2;
  assign icache_address = pc;
  assign if_inst        = inst_reg;
  assign if_valid       = state == HOLD;
  always_comb
    next_pc = (pcmux_sel == 2'b00 ? pc_inc :
               pcmux_sel == 2'b01 ? adder_target :
               pcmux_sel == 2'b10 ? reg_target : trap_vector) & 16'hFFFE;
  // icache_read is registered so it stays low through reset and rises on the first edge after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      inst_reg    <= BUBBLE;
      issued      <= 1'b0;
      icache_read <= 1'b0;
      id_inst     <= BUBBLE;
      id_pc       <= 16'h0000;
      id_valid    <= 1'b0;
    end else if (state == FETCH) begin
      if (icache_read && icache_resp) begin
        inst_reg    <= icache_rdata;
        issued      <= 1'b0;
        state       <= HOLD;
        icache_read <= 1'b0;
      end else begin
        icache_read <= 1'b1;
      end
      if (!pipe_stall) begin
        id_inst  <= BUBBLE;
        id_valid <= 1'b0;
      end
    end else if (!pipe_stall) begin
      if (ctl_issue && !issued) begin
        id_inst  <= ctl_inst;
        id_pc    <= pc_inc;
        id_valid <= 1'b1;
        issued   <= 1'b1;
      end else begin
        id_inst  <= BUBBLE;
        id_valid <= 1'b0;
      end
      if (pc_run) begin
        pc          <= next_pc;
        state       <= FETCH;
        icache_read <= 1'b1;
      end
    end
  end
endmodule
